pipe_reg_scoreboard: RTL and testbench
======================================

# pipe_reg_scoreboard

Register-hazard scoreboard for the Y86-64 pipeline's 15-entry register file. Tracks in-flight writes per architectural register, from decode issue to writeback retire or squash. Drives the decode-stage stall so no instruction reads a register with a pending write. Provides a drain sequence that empties the pipeline before halt or exception handling.

## Interface
Parameters:
- NREG, 15, number of architectural registers (indices 0..NREG-1; 4'hF = no register)
- CNT_W, 3, width of each per-register pending counter (max 7 in flight)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- D_srcA  in  4  decode source A register (4'hF = none)
- D_srcB  in  4  decode source B register (4'hF = none)
- issue_valid  in  1  instruction leaves decode this cycle; claims its destinations
- issue_dstE  in  4  destination E of issuing instruction (4'hF = none)
- issue_dstM  in  4  destination M of issuing instruction (4'hF = none)
- wb_valid  in  1  instruction in writeback retires this cycle
- W_dstE  in  4  writeback destination E
- W_dstM  in  4  writeback destination M
- kill_valid  in  1  one squashed in-flight instruction releases its claims
- kill_dstE  in  4  squashed destination E
- kill_dstM  in  4  squashed destination M
- drain_req  in  1  request to empty all pending writes
- stall_D  out  1  hold decode / block issue (combinational)
- busy  out  NREG  bit r = counter r nonzero (registered state)
- drain_done  out  1  one-cycle pulse when drain completes
- sb_err  out  1  sticky: counter over/underflow attempted

## Operation
- Per register r, counter cnt[r] (CNT_W bits). Per cycle, net delta = inc − dec.
- inc: +1 for each of issue_dstE, issue_dstM equal to r when issue_valid. Both fields equal to r (popq %rsp) gives +2.
- dec: +1 for each of W_dstE, W_dstM equal to r when wb_valid, plus +1 for each of kill_dstE, kill_dstM equal to r when kill_valid.
- Issue, writeback and kill to the same register in one cycle combine by net delta. Example: +1 −1 leaves the counter unchanged.
- Index 4'hF and indices ≥ NREG never touch any counter.
- If cnt+delta > 2^CNT_W−1 or < 0: counter holds its old value and sb_err sets. sb_err clears only on rst.
- stall_D = 1 when any of the following holds:
  - a non-F source has cnt ≠ 0;
  - any non-F issue destination has cnt ≥ 2^CNT_W−2;
  - FSM is not RUN.
- stall_D uses current counter state only; a same-cycle writeback release does not clear the stall until the next cycle.
- issue_valid while stall_D=1 is still counted; upstream is responsible for gating it.
- FSM states:
  - RUN: normal operation; drain_req=1 → DRAIN.
  - DRAIN: stall_D forced 1. When all counters are 0 (registered state), → DONE and pulse drain_done. wb_valid and kill_valid continue to decrement.
  - DONE: stall_D forced 1, drain_done=0. drain_req=0 → RUN.
- drain_req deasserted during DRAIN: remain in DRAIN until empty, then proceed to DONE.

## Timing
- Reset values: all cnt=0, busy=0, sb_err=0, drain_done=0, FSM=RUN. After reset, stall_D=0 unless the issue-destination condition fires (it cannot with all counters at 0).
- Counter update: registered at the rising clk edge; busy reflects it the following cycle.
- stall_D: combinational, same-cycle function of D_srcA/D_srcB/issue_dst and registered state.
- Drain completion: drain_done asserts in the cycle after the edge at which the counters are observed all-zero in DRAIN. If all counters are already 0 when DRAIN is entered, drain_done is high exactly 2 cycles after drain_req is first sampled.
- rst mid-drain or mid-count: everything returns to reset values at that edge; no drain_done pulse.

## Test plan
- Reset, then issue dstE=3 → busy[3]=1 next cycle; D_srcA=3 gives stall_D=1; wb_valid with W_dstE=3 → cnt[3]=0, stall_D=0 the cycle after.
- popq %rsp: issue dstE=4, dstM=4 → cnt[4]=2; one wb with both fields =4 → cnt[4]=0.
- Same cycle: issue dstE=2 and wb W_dstE=2 with cnt[2]=1 → cnt[2] stays 1, busy[2]=1.
- Kill: issue dstE=5, then kill_dstE=5 → cnt[5]=0; a further kill of 5 → counter held at 0, sb_err=1 and sticky.
- Saturation: issue dstE=6 repeatedly; at cnt[6]=6, an issue to 6 gives stall_D=1; forcing issue at cnt=7 → sb_err=1, counter stays 7.
- Drain: cnt[1]=1, assert drain_req → stall_D=1; wb releases 1 → drain_done single pulse, FSM DONE; drop drain_req → RUN, stall_D=0.

Source files
------------

// File: rtl/pipe_reg_scoreboard_if.sv
// Decode/writeback/kill bus of the register-hazard scoreboard.
//   master: pipeline side, drives sources, issue/wb/kill claims and drain_req;
//           receives stall_D, busy, drain_done, sb_err.
//   slave : scoreboard side, the mirror image.
interface pipe_reg_scoreboard_if #(
  parameter int unsigned NREG = 15
);
  logic [3:0]      D_srcA;
  logic [3:0]      D_srcB;
  logic            issue_valid;
  logic [3:0]      issue_dstE;
  logic [3:0]      issue_dstM;
  logic            wb_valid;
  logic [3:0]      W_dstE;
  logic [3:0]      W_dstM;
  logic            kill_valid;
  logic [3:0]      kill_dstE;
  logic [3:0]      kill_dstM;
  logic            drain_req;
  logic            stall_D;
  logic [NREG-1:0] busy;
  logic            drain_done;
  logic            sb_err;

  modport master (
    output D_srcA, D_srcB, issue_valid, issue_dstE, issue_dstM,
           wb_valid, W_dstE, W_dstM, kill_valid, kill_dstE, kill_dstM,
           drain_req,
    input  stall_D, busy, drain_done, sb_err
  );

  modport slave (
    input  D_srcA, D_srcB, issue_valid, issue_dstE, issue_dstM,
           wb_valid, W_dstE, W_dstM, kill_valid, kill_dstE, kill_dstM,
           drain_req,
    output stall_D, busy, drain_done, sb_err
  );
endinterface

// File: rtl/pipe_reg_scoreboard.sv
// Register-hazard scoreboard: one pending-write counter per architectural
// register, incremented at decode issue and decremented at writeback retire
// or squash. Generates the decode stall and a drain sequence.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pipe_reg_scoreboard_if (sources, issue/wb/kill
//              destinations, drain_req in; stall_D, busy, drain_done,
//              sb_err out)
module pipe_reg_scoreboard #(
  parameter int unsigned NREG  = 15,
  parameter int unsigned CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_reg_scoreboard_if.slave  bus
);

  // Headroom for cnt + 2 increments and up to 4 decrements.
  localparam int unsigned DW   = CNT_W + 2;
  localparam int unsigned CMAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [DW-1:0]    up      [NREG];
  logic [DW-1:0]    dn      [NREG];
  logic [NREG-1:0]  busy_v;
  logic             ovf;
  logic             stall;
  logic             drain_done_q;
  logic             sb_err_q;
  logic             all_zero;

  // Field addresses register r; 4'hF never matches.
  function automatic logic match(input logic [3:0] idx, input int unsigned r);
    return (idx != 4'hF) && (idx == 4'(r));
  endfunction

  function automatic logic [DW-1:0] hit(input logic v, input logic [3:0] idx,
                                        input int unsigned r);
    return (v && match(idx, r)) ? DW'(1) : DW'(0);
  endfunction

  // Net per-register update; an out-of-range result holds the counter.
  always_comb begin
    ovf = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      up[r] = DW'(cnt[r]) + hit(bus.issue_valid, bus.issue_dstE, r)
                          + hit(bus.issue_valid, bus.issue_dstM, r);
      dn[r] = hit(bus.wb_valid, bus.W_dstE, r) + hit(bus.wb_valid, bus.W_dstM, r)
            + hit(bus.kill_valid, bus.kill_dstE, r)
            + hit(bus.kill_valid, bus.kill_dstM, r);
      cnt_nxt[r] = cnt[r];
      if ((up[r] < dn[r]) || ((up[r] - dn[r]) > DW'(CMAX))) begin
        ovf = 1'b1;
      end else begin
        cnt_nxt[r] = CNT_W'(up[r] - dn[r]);
      end
    end
  end

  // Decode stall from registered state only.
  always_comb begin
    stall = (state != ST_RUN);
    for (int unsigned r = 0; r < NREG; r++) begin
      if ((cnt[r] != '0) && (match(bus.D_srcA, r) || match(bus.D_srcB, r))) begin
        stall = 1'b1;
      end
      if ((cnt[r] >= CNT_W'(CMAX - 1)) &&
          (match(bus.issue_dstE, r) || match(bus.issue_dstM, r))) begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    busy_v = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      busy_v[r] = (cnt[r] != '0);
    end
  end

  assign all_zero = ~|busy_v;

  // Counters, sticky error and drain FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      drain_done_q <= 1'b0;
      sb_err_q     <= 1'b0;
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      sb_err_q     <= sb_err_q | ovf;
      drain_done_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (bus.drain_req) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (all_zero) begin
            state        <= ST_DONE;
            drain_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!bus.drain_req) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.stall_D    = stall;
  assign bus.busy       = busy_v;
  assign bus.drain_done = drain_done_q;
  assign bus.sb_err     = sb_err_q;

endmodule

// File: tb/tb_pipe_reg_scoreboard.sv
// Self-checking bench for pipe_reg_scoreboard: directed scenarios plus a
// randomized run against a counter-array reference model.
module tb_pipe_reg_scoreboard;

  localparam int unsigned NREG = 15;
  localparam int CMAX    = 7;
  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_DONE  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_reg_scoreboard_if #(.NREG(NREG)) sb_if ();

  pipe_reg_scoreboard #(.NREG(NREG), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sb_if)
  );

  int total;
  int bad;

  // Reference model state.
  int mcnt [NREG];
  bit merr;
  bit mdone;
  int mmode;

  function automatic int hits(logic v, logic [3:0] a, logic [3:0] b, int r);
    int n;
    n = 0;
    if (v && a != 4'hF && int'(a) == r) n++;
    if (v && b != 4'hF && int'(b) == r) n++;
    return n;
  endfunction

  function automatic int pend(logic [3:0] x);
    if (x == 4'hF) return 0;
    return mcnt[int'(x)];
  endfunction

  function automatic bit exp_stall();
    if (mmode != M_RUN) return 1'b1;
    if (pend(sb_if.D_srcA) != 0 || pend(sb_if.D_srcB) != 0) return 1'b1;
    if (sb_if.issue_dstE != 4'hF && pend(sb_if.issue_dstE) >= CMAX - 1) return 1'b1;
    if (sb_if.issue_dstM != 4'hF && pend(sb_if.issue_dstM) >= CMAX - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NREG-1:0] exp_busy();
    logic [NREG-1:0] b;
    b = '0;
    for (int r = 0; r < int'(NREG); r++) b[r] = (mcnt[r] != 0);
    return b;
  endfunction

  task automatic idle();
    sb_if.D_srcA      = 4'hF;
    sb_if.D_srcB      = 4'hF;
    sb_if.issue_valid = 1'b0;
    sb_if.issue_dstE  = 4'hF;
    sb_if.issue_dstM  = 4'hF;
    sb_if.wb_valid    = 1'b0;
    sb_if.W_dstE      = 4'hF;
    sb_if.W_dstM      = 4'hF;
    sb_if.kill_valid  = 1'b0;
    sb_if.kill_dstE   = 4'hF;
    sb_if.kill_dstM   = 4'hF;
    sb_if.drain_req   = 1'b0;
  endtask

  // One clock edge; the model advances from the inputs held before the edge.
  task automatic tick();
    int  nxt [NREG];
    int  n;
    bit  err;
    bit  allz;
    bit  rs;
    bit  dreq;
    err  = 1'b0;
    allz = 1'b1;
    rs   = rst;
    dreq = sb_if.drain_req;
    for (int r = 0; r < int'(NREG); r++) begin
      if (mcnt[r] != 0) allz = 1'b0;
      n = mcnt[r]
        + hits(sb_if.issue_valid, sb_if.issue_dstE, sb_if.issue_dstM, r)
        - hits(sb_if.wb_valid, sb_if.W_dstE, sb_if.W_dstM, r)
        - hits(sb_if.kill_valid, sb_if.kill_dstE, sb_if.kill_dstM, r);
      if (n < 0 || n > CMAX) begin
        nxt[r] = mcnt[r];
        err = 1'b1;
      end else begin
        nxt[r] = n;
      end
    end
    @(posedge clk);
    if (rs) begin
      for (int r = 0; r < int'(NREG); r++) mcnt[r] = 0;
      merr  = 1'b0;
      mdone = 1'b0;
      mmode = M_RUN;
    end else begin
      for (int r = 0; r < int'(NREG); r++) mcnt[r] = nxt[r];
      merr  = merr | err;
      mdone = 1'b0;
      if (mmode == M_RUN && dreq) mmode = M_DRAIN;
      else if (mmode == M_DRAIN && allz) begin
        mmode = M_DONE;
        mdone = 1'b1;
      end else if (mmode == M_DONE && !dreq) mmode = M_RUN;
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (sb_if.busy !== '0) begin
      bad++; $display("FAIL reset_busy: got %0h want 0", sb_if.busy);
    end
    total++;
    if (sb_if.sb_err !== 1'b0) begin
      bad++; $display("FAIL reset_sb_err: got %0b want 0", sb_if.sb_err);
    end
    total++;
    if (sb_if.drain_done !== 1'b0) begin
      bad++; $display("FAIL reset_drain_done: got %0b want 0", sb_if.drain_done);
    end
    total++;
    if (sb_if.stall_D !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %0b want 0", sb_if.stall_D);
    end
  endtask

  task automatic test_basic();
    do_reset();
    sb_if.issue_valid = 1'b1;
    sb_if.issue_dstE  = 4'd3;
    tick();
    idle();
    sb_if.D_srcA = 4'd3;
    #1;
    total++;
    if (sb_if.busy !== 15'h0008) begin
      bad++; $display("FAIL basic_busy3: got %0h want 8", sb_if.busy);
    end
    total++;
    if (sb_if.stall_D !== 1'b1) begin
      bad++; $display("FAIL basic_stall_src: got %0b want 1", sb_if.stall_D);
    end
    sb_if.wb_valid = 1'b1;
    sb_if.W_dstE   = 4'd3;
    #1;
    total++;
    if (sb_if.stall_D !== 1'b1) begin
      bad++; $display("FAIL basic_stall_same_cycle_wb: got %0b want 1", sb_if.stall_D);
    end
    tick();
    idle();
    sb_if.D_srcA = 4'd3;
    #1;
    total++;
    if (sb_if.busy !== '0) begin
      bad++; $display("FAIL basic_busy_after_wb: got %0h want 0", sb_if.busy);
    end
    total++;
    if (sb_if.stall_D !== 1'b0) begin
      bad++; $display("FAIL basic_stall_after_wb: got %0b want 0", sb_if.stall_D);
    end
  endtask

  task automatic test_popq();
    do_reset();
    sb_if.issue_valid = 1'b1;
    sb_if.issue_dstE  = 4'd4;
    sb_if.issue_dstM  = 4'd4;
    tick();
    idle();
    total++;
    if (dut.cnt[4] !== 3'd2) begin
      bad++; $display("FAIL popq_cnt2: got %0d want 2", dut.cnt[4]);
    end
    sb_if.wb_valid = 1'b1;
    sb_if.W_dstE   = 4'd4;
    sb_if.W_dstM   = 4'd4;
    tick();
    idle();
    total++;
    if (dut.cnt[4] !== 3'd0 || sb_if.sb_err !== 1'b0) begin
      bad++; $display("FAIL popq_release: got cnt=%0d err=%0b want 0/0", dut.cnt[4], sb_if.sb_err);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    sb_if.issue_valid = 1'b1;
    sb_if.issue_dstE  = 4'd2;
    tick();
    sb_if.wb_valid = 1'b1;
    sb_if.W_dstE   = 4'd2;
    tick();
    idle();
    total++;
    if (dut.cnt[2] !== 3'd1 || sb_if.busy !== 15'h0004) begin
      bad++; $display("FAIL same_cycle_net: got cnt=%0d busy=%0h want 1/4", dut.cnt[2], sb_if.busy);
    end
  endtask

  task automatic test_kill();
    do_reset();
    sb_if.issue_valid = 1'b1;
    sb_if.issue_dstE  = 4'd5;
    tick();
    idle();
    sb_if.kill_valid = 1'b1;
    sb_if.kill_dstE  = 4'd5;
    tick();
    total++;
    if (dut.cnt[5] !== 3'd0 || sb_if.sb_err !== 1'b0) begin
      bad++; $display("FAIL kill_release: got cnt=%0d err=%0b want 0/0", dut.cnt[5], sb_if.sb_err);
    end
    tick();
    idle();
    total++;
    if (dut.cnt[5] !== 3'd0 || sb_if.sb_err !== 1'b1) begin
      bad++; $display("FAIL kill_underflow: got cnt=%0d err=%0b want 0/1", dut.cnt[5], sb_if.sb_err);
    end
    tick();
    tick();
    total++;
    if (sb_if.sb_err !== 1'b1) begin
      bad++; $display("FAIL kill_err_sticky: got %0b want 1", sb_if.sb_err);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    sb_if.issue_dstE = 4'd6;
    for (int i = 0; i < 5; i++) begin
      sb_if.issue_valid = 1'b1;
      tick();
    end
    sb_if.issue_valid = 1'b0;
    #1;
    total++;
    if (sb_if.stall_D !== 1'b0) begin
      bad++; $display("FAIL sat_stall_at5: got %0b want 0", sb_if.stall_D);
    end
    sb_if.issue_valid = 1'b1;
    tick();
    sb_if.issue_valid = 1'b0;
    #1;
    total++;
    if (sb_if.stall_D !== 1'b1 || dut.cnt[6] !== 3'd6) begin
      bad++; $display("FAIL sat_stall_at6: got stall=%0b cnt=%0d want 1/6", sb_if.stall_D, dut.cnt[6]);
    end
    sb_if.issue_valid = 1'b1;
    tick();
    total++;
    if (dut.cnt[6] !== 3'd7 || sb_if.sb_err !== 1'b0) begin
      bad++; $display("FAIL sat_reach7: got cnt=%0d err=%0b want 7/0", dut.cnt[6], sb_if.sb_err);
    end
    tick();
    idle();
    total++;
    if (dut.cnt[6] !== 3'd7 || sb_if.sb_err !== 1'b1) begin
      bad++; $display("FAIL sat_overflow: got cnt=%0d err=%0b want 7/1", dut.cnt[6], sb_if.sb_err);
    end
  endtask

  task automatic test_drain();
    do_reset();
    sb_if.issue_valid = 1'b1;
    sb_if.issue_dstE  = 4'd1;
    tick();
    idle();
    sb_if.drain_req = 1'b1;
    tick();
    total++;
    if (sb_if.stall_D !== 1'b1 || sb_if.drain_done !== 1'b0) begin
      bad++; $display("FAIL drain_enter: got stall=%0b done=%0b want 1/0", sb_if.stall_D, sb_if.drain_done);
    end
    sb_if.wb_valid = 1'b1;
    sb_if.W_dstE   = 4'd1;
    tick();
    sb_if.wb_valid = 1'b0;
    sb_if.W_dstE   = 4'hF;
    total++;
    if (sb_if.drain_done !== 1'b0) begin
      bad++; $display("FAIL drain_early_done: got %0b want 0", sb_if.drain_done);
    end
    tick();
    total++;
    if (sb_if.drain_done !== 1'b1 || sb_if.stall_D !== 1'b1) begin
      bad++; $display("FAIL drain_done_pulse: got done=%0b stall=%0b want 1/1", sb_if.drain_done, sb_if.stall_D);
    end
    tick();
    total++;
    if (sb_if.drain_done !== 1'b0 || sb_if.stall_D !== 1'b1) begin
      bad++; $display("FAIL drain_done_hold: got done=%0b stall=%0b want 0/1", sb_if.drain_done, sb_if.stall_D);
    end
    sb_if.drain_req = 1'b0;
    tick();
    total++;
    if (sb_if.stall_D !== 1'b0) begin
      bad++; $display("FAIL drain_back_to_run: got stall=%0b want 0", sb_if.stall_D);
    end
  endtask

  task automatic test_drain_empty();
    do_reset();
    sb_if.drain_req = 1'b1;
    tick();
    sb_if.drain_req = 1'b0;
    total++;
    if (sb_if.drain_done !== 1'b0 || sb_if.stall_D !== 1'b1) begin
      bad++; $display("FAIL empty_drain_cycle1: got done=%0b stall=%0b want 0/1", sb_if.drain_done, sb_if.stall_D);
    end
    tick();
    total++;
    if (sb_if.drain_done !== 1'b1) begin
      bad++; $display("FAIL empty_drain_cycle2: got done=%0b want 1", sb_if.drain_done);
    end
    tick();
    total++;
    if (sb_if.drain_done !== 1'b0 || sb_if.stall_D !== 1'b0) begin
      bad++; $display("FAIL empty_drain_exit: got done=%0b stall=%0b want 0/0", sb_if.drain_done, sb_if.stall_D);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    sb_if.issue_valid = 1'b1;
    sb_if.issue_dstE  = 4'd1;
    tick();
    idle();
    sb_if.drain_req = 1'b1;
    tick();
    sb_if.wb_valid = 1'b1;
    sb_if.W_dstE   = 4'd1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    total++;
    if (sb_if.drain_done !== 1'b0 || sb_if.stall_D !== 1'b0 || sb_if.busy !== '0) begin
      bad++; $display("FAIL reset_mid_drain: got done=%0b stall=%0b busy=%0h want 0/0/0",
                      sb_if.drain_done, sb_if.stall_D, sb_if.busy);
    end
    tick();
    total++;
    if (sb_if.drain_done !== 1'b0 || sb_if.sb_err !== 1'b0) begin
      bad++; $display("FAIL reset_mid_drain_after: got done=%0b err=%0b want 0/0", sb_if.drain_done, sb_if.sb_err);
    end
  endtask

  task automatic test_random();
    bit dreq;
    do_reset();
    dreq = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      sb_if.D_srcA      = 4'($urandom_range(0, 15));
      sb_if.D_srcB      = 4'($urandom_range(0, 15));
      sb_if.issue_valid = ($urandom_range(0, 99) < 50);
      sb_if.issue_dstE  = 4'($urandom_range(0, 15));
      sb_if.issue_dstM  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      sb_if.wb_valid    = ($urandom_range(0, 99) < 40);
      sb_if.W_dstE      = 4'($urandom_range(0, 15));
      sb_if.W_dstM      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      sb_if.kill_valid  = ($urandom_range(0, 99) < 15);
      sb_if.kill_dstE   = 4'($urandom_range(0, 15));
      sb_if.kill_dstM   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 5) dreq = ~dreq;
      sb_if.drain_req   = dreq;
      rst = ($urandom_range(0, 99) < 2) || (cyc % 80 == 79);
      #1;
      total++;
      if (sb_if.stall_D !== exp_stall()) begin
        bad++; $display("FAIL rand_stall cyc=%0d: got %0b want %0b", cyc, sb_if.stall_D, exp_stall());
      end
      tick();
      rst = 1'b0;
      total++;
      if (sb_if.busy !== exp_busy() || sb_if.sb_err !== merr || sb_if.drain_done !== mdone) begin
        bad++; $display("FAIL rand_state cyc=%0d: got busy=%0h err=%0b done=%0b want %0h/%0b/%0b",
                        cyc, sb_if.busy, sb_if.sb_err, sb_if.drain_done, exp_busy(), merr, mdone);
      end
      for (int r = 0; r < int'(NREG); r++) begin
        total++;
        if (dut.cnt[r] !== 3'(mcnt[r])) begin
          bad++; $display("FAIL rand_cnt cyc=%0d r=%0d: got %0d want %0d", cyc, r, dut.cnt[r], mcnt[r]);
        end
      end
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int r = 0; r < int'(NREG); r++) mcnt[r] = 0;
    merr  = 1'b0;
    mdone = 1'b0;
    mmode = M_RUN;
    rst   = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_basic();
    test_popq();
    test_same_cycle();
    test_kill();
    test_saturation();
    test_drain();
    test_drain_empty();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
